data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the MEM/WB data-memory port of the RV32 pipeline and a line-wide backing memory. It serves word and byte-enabled accesses from the core in the same cycle on a hit. On a miss it raises `miss`, which drives the hazard unit's `DCacheMiss` input. A refill FSM writes back a dirty victim if needed, fetches the line, then lets the stalled access complete as a hit.

## Interface
Parameters:
- `LINE_ADDR_LEN`, default 3: log2 of words per line (8 words, 256-bit line).
- `SET_ADDR_LEN`, default 6: log2 of number of sets (64).
- `TAG_ADDR_LEN`, derived: 30 − `LINE_ADDR_LEN` − `SET_ADDR_LEN`. Address bits [1:0] are ignored.

Ports:
- `CPU_CLK` in 1: clock, all state updates on rising edge.
- `CPU_RST` in 1: reset, asynchronous, active-high.
- `rd_req` in 1: load request this cycle.
- `wr_req` in 4: byte-enable of a store (MemWriteM encoding); nonzero means store.
- `addr` in 32: byte address.
- `wr_data` in 32: store data, byte lanes aligned to `addr[1:0]`=0.
- `rd_data` out 32: whole word at `addr`, combinational on hit.
- `miss` out 1: access in progress not yet satisfied; core must stall.
- `mem_rd_req` out 1: line fetch request, held until `mem_gnt`.
- `mem_wr_req` out 1: line write-back request, held until `mem_gnt`.
- `mem_addr` out 32: line-aligned byte address of current memory request.
- `mem_wr_line` out 32<<LINE_ADDR_LEN: victim line data.
- `mem_rd_line` in 32<<LINE_ADDR_LEN: fetched line, valid when `mem_gnt`=1.
- `mem_gnt` in 1: one-cycle completion pulse for the outstanding request.
- `hit_count`, `miss_count` out 32: performance counters.

## Operation
- Per set: `valid`, `dirty`, tag, line data, all in registers.
- `hit` = `valid[set]` & (`tag[set]` == addr tag), evaluated only while state = IDLE.
- States:
  - IDLE → no request or hit: stay. A hit on a store merges the enabled bytes into the word and sets `dirty`.
  - IDLE → miss with victim `valid` & `dirty`: go to SWAP_OUT.
  - IDLE → miss otherwise: go to SWAP_IN.
  - SWAP_OUT: `mem_wr_req`=1, `mem_addr` = {victim tag, set, 0}, `mem_wr_line` = victim data. On `mem_gnt` → SWAP_IN.
  - SWAP_IN: `mem_rd_req`=1, `mem_addr` = {addr tag, set, 0}. On `mem_gnt`, latch `mem_rd_line` into a refill buffer → SWAP_IN_OK.
  - SWAP_IN_OK: write the refill buffer into the set, set `valid`=1, `dirty`=0, load the tag → IDLE. The held access then hits in IDLE.
- `miss` = (`rd_req` | `|wr_req`) & (state ≠ IDLE | ~hit). With no request, `miss`=0 even mid-refill. The core holds the request stable while stalled.
- `rd_req` and nonzero `wr_req` in the same cycle are treated as a store. `rd_data` shows the pre-merge word.
- Counters: `hit_count` increments once per access that hits in IDLE. `miss_count` increments once per IDLE→SWAP_OUT/SWAP_IN transition. Both wrap modulo 2^32.
- `rd_data` is 0 when there is no hit.

## Timing
- Reset state: state IDLE, all `valid`/`dirty` = 0, counters 0. All outputs 0: `miss`, `mem_rd_req`, `mem_wr_req`, `mem_addr`, `rd_data`.
- Reset asserted mid-refill: the FSM aborts immediately and any outstanding `mem_*_req` drops in the same cycle. The partially fetched line is discarded. A `mem_gnt` arriving during or after reset while in IDLE is ignored.
- Hit latency: 0 cycles. Data is returned combinationally, and a store commits at the next edge.
- Clean miss: `miss` high from the request cycle through SWAP_IN (1 + memory latency cycles) plus the SWAP_IN_OK cycle. The access completes on the following IDLE cycle.
- Dirty miss adds the write-back latency before SWAP_IN.
- `mem_rd_req` and `mem_wr_req` are never high together. Each is held constant, with `mem_addr` stable, until `mem_gnt`.
- `mem_gnt` in IDLE or SWAP_IN_OK is ignored.

## Test plan
- Reset, then load 0x0000_0100 → `miss`=1 and `mem_rd_req` with `mem_addr`=0x100. Memory returns a line with word0=0xDEADBEEF after 5 cycles → `miss` falls and `rd_data`=0xDEADBEEF. `miss_count`=1, `hit_count`=1.
- Load 0x104 right after that refill → `miss`=0 in the same cycle, `rd_data`=word1, `mem_rd_req` never asserts.
- Store 0x11223344 with `wr_req`=4'b0011 to 0x100 (old value 0xDEADBEEF), then load 0x100 → `rd_data`=0xDEAD3344, no memory traffic.
- Dirty line at 0x100, then load 0x2100 (same set, different tag) → `mem_wr_req` with `mem_addr`=0x100 and word0=0xDEAD3344 in `mem_wr_line`. After `mem_gnt`, `mem_rd_req` with `mem_addr`=0x2100, then the load hits.
- Assert `CPU_RST` during SWAP_IN → `mem_rd_req`=0 immediately and all counters are 0. After release, load 0x100 misses again.
- `rd_req`=1 and `wr_req`=4'b1111 to a hit address → `rd_data` shows the old word, the new word is stored, and `hit_count` increments by exactly 1.

Source files
------------

// File: rtl/data_cache.sv
// ============================================================================
//  Module   : data_cache
//  Purpose  : Direct-mapped, write-back, write-allocate data cache with a
//             line-wide refill/write-back port to backing memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 6
) (
    input  logic                          CPU_CLK,
    input  logic                          CPU_RST,
    input  logic                          rd_req,
    input  logic [3:0]                    wr_req,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   wr_data,
    output logic [31:0]                   rd_data,
    output logic                          miss,
    output logic                          mem_rd_req,
    output logic                          mem_wr_req,
    output logic [31:0]                   mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0] mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0] mem_rd_line,
    input  logic                          mem_gnt,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam int WORDS        = 1 << LINE_ADDR_LEN;
    localparam int LINE_W       = 32 << LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SETS-1:0]         r_valid;
    logic [SETS-1:0]         r_dirty;
    logic [TAG_ADDR_LEN-1:0] r_tag      [SETS];
    logic [31:0]             r_lineData [SETS][WORDS];
    logic [LINE_W-1:0]       r_refill;

    logic [LINE_ADDR_LEN-1:0] w_word;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic                     w_req;
    logic                     w_store;
    logic                     w_hit;
    logic [31:0]              w_hitWord;
    logic [31:0]              w_mergedWord;
    logic [LINE_W-1:0]        w_victimLine;
    logic                     w_unused;

    assign w_word    = addr[LINE_ADDR_LEN+1:2];
    assign w_set     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign w_tag     = addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign w_unused  = &{1'b0, addr[1:0]};
    assign w_req     = rd_req | (|wr_req);
    assign w_store   = |wr_req;
    assign w_hit     = (r_state == IDLE) && r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_hitWord = r_lineData[w_set][w_word];
    assign rd_data   = w_hit ? w_hitWord : 32'd0;

    generate
        for (genvar i = 0; i < WORDS; i++) begin : g_victim
            assign w_victimLine[i*32 +: 32] = r_lineData[w_set][i];
        end
    endgenerate

    always_comb begin
        w_mergedWord = w_hitWord;
        for (int b = 0; b < 4; b++) begin
            if (wr_req[b]) begin
                w_mergedWord[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        miss        = w_req & ((r_state != IDLE) | ~w_hit);
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = 32'd0;
        mem_wr_line = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_nextState = (r_valid[w_set] && r_dirty[w_set]) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {r_tag[w_set], w_set, {(LINE_ADDR_LEN+2){1'b0}}};
                mem_wr_line = w_victimLine;
                if (mem_gnt) begin
                    w_nextState = SWAP_IN;
                end
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {w_tag, w_set, {(LINE_ADDR_LEN+2){1'b0}}};
                if (mem_gnt) begin
                    w_nextState = SWAP_IN_OK;
                end
            end
            SWAP_IN_OK: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Refill buffer decouples the memory grant from the array write.
    always_ff @(posedge CPU_CLK) begin
        if (r_state == SWAP_IN && mem_gnt) begin
            r_refill <= mem_rd_line;
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == SWAP_IN_OK) begin
            r_valid[w_set] <= 1'b1;
            r_dirty[w_set] <= 1'b0;
        end else if (w_hit && w_store) begin
            r_dirty[w_set] <= 1'b1;
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (r_state == SWAP_IN_OK) begin
            r_tag[w_set] <= w_tag;
            for (int i = 0; i < WORDS; i++) begin
                r_lineData[w_set][i] <= r_refill[i*32 +: 32];
            end
        end else if (w_hit && w_store) begin
            r_lineData[w_set][w_word] <= w_mergedWord;
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (w_hit && w_req) begin
                hit_count <= hit_count + 32'd1;
            end
            if (r_state == IDLE && w_req && !w_hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// ============================================================================
//  Module   : tb_data_cache
//  Purpose  : Directed self-checking bench for data_cache.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache;

    localparam int LW = 256;

    logic          CPU_CLK;
    logic          CPU_RST;
    logic          rd_req;
    logic [3:0]    wr_req;
    logic [31:0]   addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          miss;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic [LW-1:0] mem_rd_line;
    logic          mem_gnt;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    int checks   = 0;
    int failures = 0;

    logic [LW-1:0] line100;
    logic [LW-1:0] line2100;
    logic [LW-1:0] lineJunk;

    data_cache dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST     (CPU_RST),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side: wait for a request, check it, then grant after lat cycles.
    task automatic serve(input bit isWr, input logic [31:0] expAddr, input logic [31:0] expW0,
                         input int lat, input logic [LW-1:0] line, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CPU_CLK);
            #1;
            ok = isWr ? mem_wr_req : mem_rd_req;
        end
        chk({tag, "_req"}, {31'd0, ok}, 32'd1);
        chk({tag, "_addr"}, mem_addr, expAddr);
        chk({tag, "_excl"}, {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
        if (isWr) chk({tag, "_w0"}, mem_wr_line[31:0], expW0);
        repeat (lat - 1) @(negedge CPU_CLK);
        #1;
        chk({tag, "_hold"}, {31'd0, isWr ? mem_wr_req : mem_rd_req}, 32'd1);
        chk({tag, "_addrhold"}, mem_addr, expAddr);
        mem_rd_line = line;
        mem_gnt     = 1'b1;
        @(negedge CPU_CLK);
        mem_gnt     = 1'b0;
    endtask

    initial begin
        bit seen;
        line100 = '0;
        line2100 = '0;
        for (int i = 0; i < 8; i++) begin
            line100[i*32 +: 32]  = 32'h1000_0000 + i;
            line2100[i*32 +: 32] = 32'hA000_0000 + i;
        end
        line100[31:0]  = 32'hDEADBEEF;
        line100[63:32] = 32'hCAFE0001;
        lineJunk = {8{32'h0BAD0BAD}};

        CPU_RST = 1'b1; rd_req = 1'b0; wr_req = 4'd0; addr = 32'd0; wr_data = 32'd0;
        mem_rd_line = '0; mem_gnt = 1'b0;
        repeat (3) @(negedge CPU_CLK);
        #1;
        chk("rst_miss", {31'd0, miss}, 32'd0);
        chk("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
        chk("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;

        // Cold load miss on 0x100
        @(negedge CPU_CLK);
        rd_req = 1'b1; addr = 32'h100;
        #1;
        chk("cold_miss", {31'd0, miss}, 32'd1);
        chk("cold_no_req_yet", {31'd0, mem_rd_req}, 32'd0);
        serve(1'b0, 32'h100, 32'd0, 5, line100, "cold_rd");
        #1;
        chk("cold_swapin_ok_miss", {31'd0, miss}, 32'd1);
        chk("cold_swapin_ok_norq", {31'd0, mem_rd_req}, 32'd0);
        @(negedge CPU_CLK);
        #1;
        chk("cold_done_miss", {31'd0, miss}, 32'd0);
        chk("cold_done_data", rd_data, 32'hDEADBEEF);
        chk("cold_miss_count", miss_count, 32'd1);

        // Same-line load hits immediately
        @(negedge CPU_CLK);
        addr = 32'h104;
        #1;
        chk("cold_hit_count", hit_count, 32'd1);
        chk("w1_miss", {31'd0, miss}, 32'd0);
        chk("w1_data", rd_data, 32'hCAFE0001);
        chk("w1_no_mem", {31'd0, mem_rd_req}, 32'd0);

        // Byte-enabled store hit, then reload
        @(negedge CPU_CLK);
        rd_req = 1'b0; wr_req = 4'b0011; addr = 32'h100; wr_data = 32'h11223344;
        #1;
        chk("st_miss", {31'd0, miss}, 32'd0);
        chk("st_premerge", rd_data, 32'hDEADBEEF);
        @(negedge CPU_CLK);
        wr_req = 4'd0; rd_req = 1'b1;
        #1;
        chk("st_merged", rd_data, 32'hDEAD3344);
        chk("st_no_wr", {31'd0, mem_wr_req}, 32'd0);
        chk("st_no_rd", {31'd0, mem_rd_req}, 32'd0);
        chk("st_hit_count", hit_count, 32'd3);

        // Dirty conflict miss: write back 0x100, fetch 0x2100
        @(negedge CPU_CLK);
        addr = 32'h2100;
        #1;
        chk("dm_miss", {31'd0, miss}, 32'd1);
        chk("dm_hit_count", hit_count, 32'd4);
        serve(1'b1, 32'h100, 32'hDEAD3344, 3, '0, "dm_wb");
        #1;
        chk("dm_wb_w1", {31'd0, mem_wr_req}, 32'd0);
        serve(1'b0, 32'h2100, 32'd0, 2, line2100, "dm_rd");
        #1;
        chk("dm_swapin_ok_miss", {31'd0, miss}, 32'd1);
        @(negedge CPU_CLK);
        #1;
        chk("dm_done_miss", {31'd0, miss}, 32'd0);
        chk("dm_done_data", rd_data, 32'hA0000000);
        chk("dm_miss_count", miss_count, 32'd2);
        @(negedge CPU_CLK);
        addr = 32'h2104;
        #1;
        chk("dm_w1_data", rd_data, 32'hA0000001);
        chk("dm_w1_hits", hit_count, 32'd5);
        @(negedge CPU_CLK);
        rd_req = 1'b0;
        #1;
        chk("dm_idle_hits", hit_count, 32'd6);
        chk("dm_idle_miss", {31'd0, miss}, 32'd0);

        // Reset during SWAP_IN
        @(negedge CPU_CLK);
        rd_req = 1'b1; addr = 32'h4100;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CPU_CLK);
            #1;
            seen = mem_rd_req;
        end
        chk("ab_req_seen", {31'd0, seen}, 32'd1);
        chk("ab_addr", mem_addr, 32'h4100);
        chk("ab_miss_count", miss_count, 32'd3);
        @(negedge CPU_CLK);
        CPU_RST = 1'b1; mem_gnt = 1'b1; mem_rd_line = lineJunk;
        #1;
        chk("ab_rd_req_drop", {31'd0, mem_rd_req}, 32'd0);
        chk("ab_hits_zero", hit_count, 32'd0);
        chk("ab_misses_zero", miss_count, 32'd0);
        @(negedge CPU_CLK);
        mem_gnt = 1'b0; rd_req = 1'b0;
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
        mem_gnt = 1'b1;
        @(negedge CPU_CLK);
        mem_gnt = 1'b0;
        #1;
        chk("ab_gnt_ignored", {31'd0, mem_rd_req | mem_wr_req}, 32'd0);
        rd_req = 1'b1; addr = 32'h100;
        #1;
        chk("ab_reload_miss", {31'd0, miss}, 32'd1);
        serve(1'b0, 32'h100, 32'd0, 4, line100, "ab_rd");
        @(negedge CPU_CLK);
        #1;
        chk("ab_reload_data", rd_data, 32'hDEADBEEF);
        chk("ab_reload_mc", miss_count, 32'd1);
        chk("ab_reload_hc", hit_count, 32'd0);

        // Simultaneous read + full store on a hit
        @(negedge CPU_CLK);
        wr_req = 4'b1111; wr_data = 32'h55667788;
        #1;
        chk("rw_old_data", rd_data, 32'hDEADBEEF);
        chk("rw_miss", {31'd0, miss}, 32'd0);
        chk("rw_hc_before", hit_count, 32'd1);
        @(negedge CPU_CLK);
        wr_req = 4'd0;
        #1;
        chk("rw_new_data", rd_data, 32'h55667788);
        chk("rw_hc_once", hit_count, 32'd2);
        @(negedge CPU_CLK);
        rd_req = 1'b0;
        #1;
        chk("rw_hc_final", hit_count, 32'd3);
        chk("rw_no_mem", {31'd0, mem_rd_req | mem_wr_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
